// File: rtl/nios_mul_pipe.sv
// Two-stage pipelined DATA_W x DATA_W multiplier: four registered half-width
// partial products, signed corrections, and low/high word select with valid tracking.
module nios_mul_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int H  = DATA_W / 2;
  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULXSS = 2'b01,
    MODE_MULXSU = 2'b10,
    MODE_MULXUU = 2'b11
  } mode_e;

  // Stage-1 combinational inputs
  logic [H-1:0]      a_l, a_h, b_l, b_h;
  logic              a_signed, b_signed;
  logic [DATA_W-1:0] p_ll_d, p_lh_d, p_hl_d, p_hh_d;
  logic [DATA_W-1:0] corr_a_d, corr_b_d;

  // Stage-1 registers
  logic [DATA_W-1:0] p_ll_q, p_lh_q, p_hl_q, p_hh_q;
  logic [DATA_W-1:0] corr_a_q, corr_b_q;
  mode_e             mode_q;
  logic              v1_q;

  // Stage-2 signals and registers
  logic [DATA_W:0]   mid_sum, corr_sum;
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] result_d, result_q;
  logic              out_valid_q;

  assign a_l = src_a[H-1:0];
  assign a_h = src_a[DATA_W-1:H];
  assign b_l = src_b[H-1:0];
  assign b_h = src_b[DATA_W-1:H];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (mode_e'(mode))
      MODE_MULXSS: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MODE_MULXSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign p_ll_d = DATA_W'(a_l) * DATA_W'(b_l);
  assign p_lh_d = DATA_W'(a_l) * DATA_W'(b_h);
  assign p_hl_d = DATA_W'(a_h) * DATA_W'(b_l);
  assign p_hh_d = DATA_W'(a_h) * DATA_W'(b_h);

  // Two's-complement fix-up: a negative operand contributes -2^W times the other operand.
  assign corr_a_d = (a_signed && src_a[DATA_W-1]) ? src_b : '0;
  assign corr_b_d = (b_signed && src_b[DATA_W-1]) ? src_a : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_ll_q   <= '0;
      p_lh_q   <= '0;
      p_hl_q   <= '0;
      p_hh_q   <= '0;
      corr_a_q <= '0;
      corr_b_q <= '0;
      mode_q   <= MODE_MUL;
      v1_q     <= 1'b0;
    end else if (ena) begin
      p_ll_q   <= p_ll_d;
      p_lh_q   <= p_lh_d;
      p_hl_q   <= p_hl_d;
      p_hh_q   <= p_hh_d;
      corr_a_q <= corr_a_d;
      corr_b_q <= corr_b_d;
      mode_q   <= mode_e'(mode);
      v1_q     <= in_valid;
    end
  end

  // The middle sum keeps its carry; the full product is taken modulo 2^(2W).
  assign mid_sum  = {1'b0, p_lh_q} + {1'b0, p_hl_q};
  assign corr_sum = {1'b0, corr_a_q} + {1'b0, corr_b_q};
  assign prod = PW'(p_ll_q)
              + (PW'(mid_sum) << H)
              + (PW'(p_hh_q) << DATA_W)
              - (PW'(corr_sum) << DATA_W);

  always_comb begin
    result_d = result_q;
    if (v1_q) begin
      result_d = (mode_q == MODE_MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      result_q    <= result_d;
      out_valid_q <= v1_q;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign busy      = v1_q | out_valid_q;

endmodule

// File: doc/nios_mul_pipe.md
# nios_mul_pipe

Parametrised, two-stage pipelined integer multiplier for the Nios datapath. It computes the full 2×DATA_W product from four registered half-width partial products and applies signed corrections. It returns either the low word (MUL) or the high word (MULXSS/MULXSU/MULXUU) with a valid tag. It replaces the fixed 32-bit three-partial-product cell and adds high-word results, signed modes, valid tracking and a global stall.

## Interface
- DATA_W, 32, operand/result width; even, 8..64; H = DATA_W/2
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ena  in  1  pipeline advance; 0 freezes every register (stall)
- in_valid  in  1  operands/mode valid this cycle
- mode  in  2  00 MUL (low word), 01 MULXSS, 10 MULXSU (a signed, b unsigned), 11 MULXUU
- src_a  in  DATA_W  operand A
- src_b  in  DATA_W  operand B
- out_valid  out  1  result valid
- result  out  DATA_W  selected product word
- busy  out  1  any pipeline stage holds a valid operation

## Operation
- Split operands: aL = src_a[H-1:0], aH = src_a[DATA_W-1:H]; bL and bH likewise.
- Stage 1, on a clk edge with ena=1:
  - Register unsigned products pLL = aL·bL, pLH = aL·bH, pHL = aH·bL, pHH = aH·bH, each DATA_W bits.
  - Register corrections: corrA = src_b if A is treated as signed and src_a[MSB]=1, else 0; corrB = src_a if B is treated as signed and src_b[MSB]=1, else 0.
  - A is signed for modes 01 and 10. B is signed for mode 01 only.
  - Register mode, and v1 = in_valid.
- Stage 2, on a clk edge with ena=1:
  - Form the 2·DATA_W sum P = pLL + (pLH + pHL)<<H + pHH<<DATA_W − (corrA + corrB)<<DATA_W, computed modulo 2^(2·DATA_W).
  - The middle sum (pLH + pHL) must keep its carry (DATA_W+1 bits).
  - When v1=1: result ← P[DATA_W-1:0] for mode 00, else P[2·DATA_W-1:DATA_W].
  - out_valid ← v1.
  - When v1=0, result holds its previous value and out_valid ← 0.
- Mode 00 low word is independent of signedness; stage-1 corrections are forced to 0 for mode 00.
- Stage-1 data registers load regardless of in_valid; only the valid bit qualifies them.
- busy = v1 | out_valid.
- No internal FSM beyond the valid shift chain; mode and valid travel with their data.

## Timing
- Reset (reset_n=0, asynchronous): v1, out_valid, busy = 0; result = 0; all partial-product, correction and mode registers = 0. These values hold until the first enabled edge after reset_n rises.
- Latency: operands sampled at enabled edge N appear on result/out_valid after enabled edge N+1, i.e. two enabled edges.
- Throughput: one operation per enabled cycle, back-to-back, with no bubbles required.
- ena=0: all registers, including v1 and out_valid, hold exactly. Inputs presented during ena=0 are ignored. A stall of k cycles delays the output by k cycles and does not duplicate or drop it.
- ena=0 and in_valid=1 together: the operation is not accepted. The upstream stage must hold its operands until ena=1.
- Reset asserted mid-operation: in-flight operations are discarded and out_valid drops immediately, asynchronously.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- MUL, DATA_W=32, a=0x0001_0003, b=0x0002_0005, ena=1 -> after 2 edges out_valid=1, result=0x000B_000F.
- Signed modes on a=b=0xFFFF_FFFF, issued back-to-back on consecutive cycles:
  - MULXSS -> 0x0000_0000
  - MULXSU -> 0xFFFF_FFFF
  - MULXUU -> 0xFFFF_FFFE
  - All three appear on consecutive cycles with out_valid held at 1.
- MULXSS a=b=0x8000_0000 -> result=0x4000_0000. MULXSU a=0x8000_0000, b=0x0000_0002 -> result=0xFFFF_FFFF.
- Stall: issue MULXUU 0x1234_5678 × 0x9ABC_DEF0, drop ena for 3 cycles after the first edge -> out_valid, result and busy frozen during the stall. Result 0x0B00_EA4E appears exactly once, on the second enabled edge.
- Reset mid-stream: two ops in flight, pulse reset_n low between edges -> out_valid, busy and result = 0 immediately. No stale result emerges after reset is released.
- Randomised check at DATA_W=16 and DATA_W=64 against a behavioural 2·DATA_W reference model. Cover all modes, random ena/in_valid patterns, and operand corners 0, 1, MSB-only and all-ones.
